// File: rtl/ahb_lite_master_if.sv
// Command/response port and AHB-Lite bus signals of the single-transfer initiator.
// The master modport is the initiator's view; slave is the view of whatever sits on the other side.
interface ahb_lite_master_if #(
    parameter int unsigned HADDR_WIDTH = 17,
    parameter int unsigned HDATA_WIDTH = 64
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [HADDR_WIDTH-1:0] cmd_addr;
    logic                   cmd_write;
    logic [2:0]             cmd_size;
    logic [HDATA_WIDTH-1:0] cmd_wdata;

    logic                   rsp_valid;
    logic [HDATA_WIDTH-1:0] rsp_rdata;
    logic                   rsp_err;
    logic                   busy;

    logic [HADDR_WIDTH-1:0] HADDR;
    logic [1:0]             HTRANS;
    logic [2:0]             HSIZE;
    logic                   HWRITE;
    logic [HDATA_WIDTH-1:0] HWDATA;
    logic [HDATA_WIDTH-1:0] HRDATA;
    logic                   HREADY;
    logic                   HRESP;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        input  HRDATA, HREADY, HRESP,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output HADDR, HTRANS, HSIZE, HWRITE, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        output HRDATA, HREADY, HRESP,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA
    );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer initiator: pipelined address/data stages, NONSEQ singles only,
// honours wait states and the two-cycle ERROR response; responses return in command order.
module ahb_lite_master #(
    parameter int unsigned HADDR_WIDTH = 17,
    parameter int unsigned HDATA_WIDTH = 64
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_lite_master_if.master bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic                   a_valid;
    logic [HDATA_WIDTH-1:0] a_wdata;
    logic                   d_valid;
    logic                   d_write;
    logic                   handshake;
    logic                   complete;

    // An empty address stage may load even while the slave stalls the data phase.
    assign bus.cmd_ready = !a_valid | bus.HREADY;
    assign handshake     = bus.cmd_valid & bus.cmd_ready;
    assign complete      = bus.HREADY & d_valid;
    assign bus.busy      = a_valid | d_valid;
    assign bus.HTRANS    = a_valid ? HTRANS_NONSEQ : HTRANS_IDLE;

    // Address phase stage.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_valid    <= 1'b0;
            bus.HADDR  <= '0;
            bus.HWRITE <= 1'b0;
            bus.HSIZE  <= 3'd0;
            a_wdata    <= '0;
        end else if (handshake) begin
            a_valid    <= 1'b1;
            bus.HADDR  <= bus.cmd_addr;
            bus.HWRITE <= bus.cmd_write;
            bus.HSIZE  <= bus.cmd_size;
            a_wdata    <= bus.cmd_wdata;
        end else if (bus.HREADY) begin
            a_valid <= 1'b0;
        end
    end

    // Data phase stage; write data follows its address by one accepted edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            d_valid    <= 1'b0;
            d_write    <= 1'b0;
            bus.HWDATA <= '0;
        end else if (bus.HREADY) begin
            d_valid <= a_valid;
            d_write <= bus.HWRITE;
            if (a_valid && bus.HWRITE) begin
                bus.HWDATA <= a_wdata;
            end
        end
    end

    // Completion pulse; data and error hold between pulses.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= complete;
            if (complete) begin
                bus.rsp_err   <= bus.HRESP;
                bus.rsp_rdata <= (!d_write && !bus.HRESP) ? bus.HRDATA : '0;
            end
        end
    end
endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: behavioural AHB-Lite slave with programmable waits
// and an error address, plus an in-order response scoreboard.
module tb_ahb_lite_master;
    localparam int unsigned AW = 17;
    localparam int unsigned DW = 64;
    localparam logic [AW-1:0] ERR_ADDR = 17'h1F000;
    localparam logic [1:0] NONSEQ = 2'b10;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        longint        hs;
        int            lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int tests;
    int fails;
    longint cyc;
    exp_t sb[$];
    logic [DW-1:0] exp_mem [int];
    int wait_wr;
    int wait_rd;

    ahb_lite_master_if #(.HADDR_WIDTH(AW), .HDATA_WIDTH(DW)) bus ();

    ahb_lite_master #(.HADDR_WIDTH(AW), .HDATA_WIDTH(DW)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input logic [13:0] w);
        return {16'hC0DE, 2'b00, w, 16'h5A5A, 2'b00, w};
    endfunction

    // Behavioural slave
    logic [DW-1:0] mem [0:16383];
    bit            written [0:16383];
    logic          s_dvalid;
    logic [AW-1:0] s_daddr;
    logic          s_dwrite;
    logic          s_err;
    int            s_wait;
    logic          s_hready;
    logic          s_hresp;
    logic [DW-1:0] s_hrdata;

    always_comb begin
        s_hready = 1'b1;
        s_hresp  = 1'b0;
        s_hrdata = 64'hDEAD_BEEF_0BAD_F00D;
        if (s_dvalid) begin
            s_hready = (s_wait == 0);
            s_hresp  = s_err;
            if (!s_dwrite)
                s_hrdata = written[s_daddr[16:3]] ? mem[s_daddr[16:3]] : pat(s_daddr[16:3]);
        end
    end

    assign bus.HREADY = s_hready;
    assign bus.HRESP  = s_hresp;
    assign bus.HRDATA = s_hrdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_dvalid <= 1'b0;
            s_daddr  <= '0;
            s_dwrite <= 1'b0;
            s_err    <= 1'b0;
            s_wait   <= 0;
        end else if (s_hready) begin
            if (s_dvalid && s_dwrite && !s_err) begin
                mem[s_daddr[16:3]]     <= bus.HWDATA;
                written[s_daddr[16:3]] <= 1'b1;
            end
            if (bus.HTRANS == NONSEQ) begin
                s_dvalid <= 1'b1;
                s_daddr  <= bus.HADDR;
                s_dwrite <= bus.HWRITE;
                s_err    <= (bus.HADDR == ERR_ADDR);
                s_wait   <= (bus.HADDR == ERR_ADDR) ? 1 : (bus.HWRITE ? wait_wr : wait_rd);
            end else begin
                s_dvalid <= 1'b0;
            end
        end else if (s_wait != 0) begin
            s_wait <= s_wait - 1;
        end
    end

    // Response scoreboard: data, error flag and latency from handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.rsp_valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL rsp_unexpected got rdata=%h err=%0b exp no response", bus.rsp_rdata, bus.rsp_err);
            end else begin
                e = sb.pop_front();
                if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
                    fails++;
                    $display("FAIL rsp_data got=%h/%0b exp=%h/%0b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
                end
                if (e.lat != 0) begin
                    tests++;
                    if (cyc - e.hs != longint'(e.lat)) begin
                        fails++;
                        $display("FAIL rsp_latency got=%0d exp=%0d", cyc - e.hs, e.lat);
                    end
                end
            end
        end
    end

    // Bus stability under wait states, plus run-length tracking of NONSEQ and rsp_valid.
    logic          p_ok;
    logic          p_hready;
    logic [1:0]    p_htrans;
    logic [AW-1:0] p_haddr;
    logic          p_hwrite;
    logic [2:0]    p_hsize;
    logic [DW-1:0] p_hwdata;
    int            n_run, last_n_run, r_run, last_r_run;

    initial begin
        p_ok = 1'b0;
        n_run = 0; last_n_run = 0; r_run = 0; last_r_run = 0;
    end

    always @(negedge clk) begin
        if (rst_n && p_ok && !p_hready) begin
            tests++;
            if (bus.HWDATA !== p_hwdata) begin
                fails++;
                $display("FAIL hold_hwdata got=%h exp=%h", bus.HWDATA, p_hwdata);
            end
            if (p_htrans == NONSEQ) begin
                tests++;
                if ({bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE} !== {p_htrans, p_haddr, p_hwrite, p_hsize}) begin
                    fails++;
                    $display("FAIL hold_addr got=%h/%h/%0b exp=%h/%h/%0b",
                             bus.HTRANS, bus.HADDR, bus.HWRITE, p_htrans, p_haddr, p_hwrite);
                end
            end
        end
        if (bus.HTRANS == NONSEQ) n_run++;
        else if (n_run != 0) begin last_n_run = n_run; n_run = 0; end
        if (bus.rsp_valid) r_run++;
        else if (r_run != 0) begin last_r_run = r_run; r_run = 0; end
        p_ok = rst_n;
        p_hready = bus.HREADY;
        p_htrans = bus.HTRANS;
        p_haddr  = bus.HADDR;
        p_hwrite = bus.HWRITE;
        p_hsize  = bus.HSIZE;
        p_hwdata = bus.HWDATA;
    end

    task automatic issue(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd, input int lat);
        exp_t e;
        int n;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_write = w;
        bus.cmd_size  = 3'd3;
        bus.cmd_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout got cmd_ready=%0b exp 1", bus.cmd_ready);
        end else begin
            e.err = (a == ERR_ADDR);
            e.hs  = cyc;
            e.lat = lat;
            if (e.err || w) e.rdata = '0;
            else e.rdata = exp_mem.exists(int'(a[16:3])) ? exp_mem[int'(a[16:3])] : pat(a[16:3]);
            if (w && !e.err) exp_mem[int'(a[16:3])] = wd;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb.size() != 0 || bus.busy) begin
            fails++;
            $display("FAIL drain_timeout got pending=%0d busy=%0b exp 0/0", sb.size(), bus.busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        tests++; if (bus.HTRANS !== 2'b00) begin fails++; $display("FAIL reset_htrans got=%h exp=0", bus.HTRANS); end
        tests++; if (bus.HADDR !== '0) begin fails++; $display("FAIL reset_haddr got=%h exp=0", bus.HADDR); end
        tests++; if ({bus.HSIZE, bus.HWRITE} !== 4'd0) begin fails++; $display("FAIL reset_hsize_hwrite got=%h/%0b exp=0/0", bus.HSIZE, bus.HWRITE); end
        tests++; if (bus.HWDATA !== '0) begin fails++; $display("FAIL reset_hwdata got=%h exp=0", bus.HWDATA); end
        tests++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_busy_ready got=%0b/%0b exp=0/1", bus.busy, bus.cmd_ready); end
        tests++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b00 || bus.rsp_rdata !== '0) begin fails++; $display("FAIL reset_rsp got=%0b/%0b/%h exp=0/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        issue(17'h00040, 1'b1, 64'h1122334455667788, 3);
        @(negedge clk);
        tests++; if (bus.HTRANS !== NONSEQ || bus.HADDR !== 17'h00040 || bus.HWRITE !== 1'b1) begin fails++; $display("FAIL wr_addr_phase got=%h/%h/%0b exp=2/00040/1", bus.HTRANS, bus.HADDR, bus.HWRITE); end
        @(negedge clk);
        tests++; if (bus.HTRANS !== 2'b00 || bus.HWDATA !== 64'h1122334455667788) begin fails++; $display("FAIL wr_data_phase got=%h/%h exp=0/1122334455667788", bus.HTRANS, bus.HWDATA); end
        wait_idle();
        issue(17'h00040, 1'b0, '0, 3);
        @(negedge clk);
        tests++; if (bus.HTRANS !== NONSEQ || bus.HWRITE !== 1'b0) begin fails++; $display("FAIL rd_addr_phase got=%h/%0b exp=2/0", bus.HTRANS, bus.HWRITE); end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) issue(AW'(i * 8), 1'b0, '0, 3);
        wait_idle();
        tests++; if (last_n_run != 4) begin fails++; $display("FAIL b2b_nonseq_run got=%0d exp=4", last_n_run); end
        tests++; if (last_r_run != 4) begin fails++; $display("FAIL b2b_rsp_run got=%0d exp=4", last_r_run); end
    endtask

    task automatic test_wait_states();
        wait_wr = 2;
        issue(17'h00080, 1'b1, 64'hCAFE_F00D_1234_5678, 5);
        issue(17'h00088, 1'b0, '0, 5);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (bus.cmd_ready !== 1'b0 || bus.HREADY !== 1'b0 || bus.HADDR !== 17'h00088 ||
                bus.HWDATA !== 64'hCAFE_F00D_1234_5678) begin
                fails++;
                $display("FAIL wait_stall got ready=%0b hready=%0b haddr=%h hwdata=%h exp 0/0/00088/cafef00d12345678",
                         bus.cmd_ready, bus.HREADY, bus.HADDR, bus.HWDATA);
            end
        end
        wait_idle();
        wait_wr = 0;
    endtask

    task automatic test_error();
        issue(ERR_ADDR, 1'b0, '0, 4);
        issue(17'h00048, 1'b0, '0, 4);
        @(negedge clk);
        tests++;
        if (bus.HRESP !== 1'b1 || bus.HREADY !== 1'b0 || bus.HTRANS !== NONSEQ || bus.HADDR !== 17'h00048) begin
            fails++;
            $display("FAIL err_first_cycle got hresp=%0b hready=%0b htrans=%h haddr=%h exp 1/0/2/00048",
                     bus.HRESP, bus.HREADY, bus.HTRANS, bus.HADDR);
        end
        wait_idle();
    endtask

    task automatic test_reset_midflight();
        issue(17'h00000, 1'b0, '0, 0);
        issue(17'h00008, 1'b0, '0, 0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        tests++; if (bus.HTRANS !== 2'b00 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL midreset_bus got=%h/%0b/%0b exp=0/0/1", bus.HTRANS, bus.busy, bus.cmd_ready); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) begin
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            tests++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL midreset_no_rsp got=%0b/%0b exp=0/0", bus.rsp_valid, bus.busy); end
        end
        @(posedge clk);
        #1;
        issue(17'h00040, 1'b0, '0, 3);
        wait_idle();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++; if (bus.HTRANS !== 2'b00 || bus.busy !== 1'b0) begin fails++; $display("FAIL idle_bus got=%h/%0b exp=0/0", bus.HTRANS, bus.busy); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        cyc = 0;
        wait_wr = 0;
        wait_rd = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_write = 1'b0;
        bus.cmd_size  = 3'd0;
        bus.cmd_wdata = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_reset_midflight();
        test_idle();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL leftover_expected got=%0d exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

AHB-Lite single-transfer initiator bridging a simple command/response port onto an AHB-Lite bus. It is the bus-master counterpart to our AHB-Lite slaves, e.g. the BRAM slave. It issues NONSEQ single transfers only, with address and data phases pipelined so back-to-back commands sustain one transfer per cycle. It honours slave wait states and the two-cycle ERROR response.

## Interface
Parameters:
- HADDR_WIDTH, 17, byte address width.
- HDATA_WIDTH, 64, data bus width; must be 32 or 64.

Ports:
- HCLK  in  1  clock; all state changes on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid; combinational: !a_valid | HREADY.
- cmd_addr  in  HADDR_WIDTH  byte address.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_size  in  3  HSIZE encoding; passed through unchecked.
- cmd_wdata  in  HDATA_WIDTH  write data, lane-placed by the caller.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  HDATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  transfer ended with HRESP=1.
- busy  out  1  a_valid | d_valid.
- HADDR  out  HADDR_WIDTH  registered.
- HTRANS  out  2  registered; 2'b00 IDLE or 2'b10 NONSEQ only.
- HSIZE  out  3  registered.
- HWRITE  out  1  registered.
- HWDATA  out  HDATA_WIDTH  registered; valid during the write data phase.
- HRDATA  in  HDATA_WIDTH  read data.
- HREADY  in  1  bus ready, from the slave mux.
- HRESP  in  1  0 OKAY, 1 ERROR.

## Operation
- Two register stages:
  - Address phase: a_valid, HADDR, HWRITE, HSIZE, a_wdata. HTRANS = a_valid ? NONSEQ : IDLE.
  - Data phase: d_valid, d_write, HWDATA.
- Command load: on a handshake edge (cmd_valid & cmd_ready), load the address stage from cmd_* and set a_valid.
  - Otherwise, if HREADY=1, clear a_valid.
  - If HREADY=0, the address stage holds.
- Accept edge (HREADY=1):
  - d_valid <= a_valid, d_write <= HWRITE.
  - HWDATA <= a_wdata when a_valid & HWRITE; otherwise HWDATA holds.
- Completion: an edge with HREADY=1 while d_valid=1. On the next cycle:
  - rsp_valid=1.
  - rsp_err=HRESP.
  - rsp_rdata = (!d_write & !HRESP) ? HRDATA : 0.
  - In every other cycle rsp_valid=0 and rsp_rdata/rsp_err hold.
- Wait states (HREADY=0):
  - HADDR, HTRANS, HWRITE, HSIZE and HWDATA stay stable.
  - An IDLE address stage may load a new command; this is the only allowed HTRANS change, IDLE to NONSEQ.
- ERROR response:
  - First cycle (HRESP=1, HREADY=0) is treated as a wait state.
  - Second cycle (HRESP=1, HREADY=1) completes the transfer with rsp_err=1.
  - A pending address phase is not cancelled; it proceeds normally.
- No bursts, locking or protection signals. HSEL is generated by the bus decoder, not by this block.
- Ordering: responses return strictly in command order, with at most 2 transfers in flight.

## Timing
- Reset values (asynchronous, while HRESETn=0):
  - HTRANS=2'b00; HADDR, HSIZE, HWRITE, HWDATA = 0.
  - a_valid=d_valid=0, so busy=0 and cmd_ready=1.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset mid-operation: in-flight transfers are dropped with no rsp_valid. The bus shows IDLE on the first cycle of reset.
- Latency with a zero-wait slave:
  - Handshake at edge E0; NONSEQ driven after E0.
  - Address accepted at E1.
  - Data phase completes at E2.
  - rsp_valid in the cycle after E2: 3 cycles from handshake.
- Each wait state adds 1 cycle. An ERROR response adds exactly 1 cycle.
- Throughput: 1 transfer per cycle with continuous cmd_valid and HREADY=1.
- Simultaneous events: completion of transfer N, address acceptance of N+1 and load of N+2 may all occur on the same edge.

## Test plan
- Write 0x1122334455667788 to 0x0040, then read 0x0040 with a zero-wait slave -> HTRANS NONSEQ for one cycle each; HWDATA valid in the write data phase; read rsp_rdata=0x1122334455667788, rsp_err=0, 3 cycles after the handshake.
- 4 back-to-back reads at 0x00,0x08,0x10,0x18 -> HTRANS=NONSEQ for 4 consecutive cycles; 4 consecutive rsp_valid pulses in order.
- Slave inserts 2 wait states on the write data phase with a read queued -> HADDR/HWRITE/HWDATA stable for 3 cycles; cmd_ready=0 while the address stage is full and HREADY=0; rsp latency 5.
- ERROR on a read at 0x1F000 followed by a pipelined read -> rsp_err=1 with rsp_rdata=0; the following read completes with rsp_err=0.
- Assert HRESETn=0 with 2 transfers in flight -> HTRANS=0 immediately; no rsp_valid; busy=0; after release, a new command completes normally.
- cmd_valid held low -> HTRANS stays IDLE and busy=0 indefinitely.
